// File: rtl/perm_pkg.sv
// Shared definitions for the iterative 320-bit permutation: widths, rotation
// amounts, round constant and controller state encoding.
package perm_pkg;

  localparam int STATE_W    = 320;
  localparam int LANE_W     = 64;
  localparam int ROUNDS_MAX = 12;
  localparam logic [3:0] ROUNDS_MAX_4 = 4'(ROUNDS_MAX);

  // Diffusion rotation pairs for lanes x0..x4.
  localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_t;

  function automatic logic [LANE_W-1:0] rc(input logic [3:0] i);
    return {56'h0, 4'hF - i, i};
  endfunction

  function automatic logic [LANE_W-1:0] ror64(input logic [LANE_W-1:0] v,
                                              input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/perm_round_ctrl_if.sv
// Request/result bundle between a hash/XOF front end and perm_round_ctrl.
// Handshake: start is honoured only in a cycle where ready=1; the result is
// valid on state_out during the single done cycle and stays put until the
// next accepted start.
interface perm_round_ctrl_if;
  import perm_pkg::*;

  logic               start;
  logic [3:0]         nrounds;
  logic [STATE_W-1:0] state_in;
  logic               ready;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] state_out;

  modport master (
    output start, nrounds, state_in,
    input  ready, busy, done, state_out
  );

  modport slave (
    input  start, nrounds, state_in,
    output ready, busy, done, state_out
  );

endinterface

// File: rtl/perm_round.sv
// One combinational permutation round: constant addition, bitsliced 5-bit
// S-box layer, then per-lane linear diffusion.
module perm_round
  import perm_pkg::*;
(
  input  logic [3:0]         rnd_i,
  input  logic [STATE_W-1:0] s_i,
  output logic [STATE_W-1:0] s_o
);

  logic [LANE_W-1:0] x [5];
  logic [LANE_W-1:0] t [5];

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      x[k] = s_i[STATE_W-1-LANE_W*k -: LANE_W];
    end
    x[2] = x[2] ^ rc(rnd_i);

    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    for (int k = 0; k < 5; k++) begin
      t[k] = ~x[k] & x[(k + 1) % 5];
    end
    for (int k = 0; k < 5; k++) begin
      x[k] = x[k] ^ t[(k + 1) % 5];
    end
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];

    for (int k = 0; k < 5; k++) begin
      x[k] = x[k] ^ ror64(x[k], ROT_A[k]) ^ ror64(x[k], ROT_B[k]);
    end
    s_o = {x[0], x[1], x[2], x[3], x[4]};
  end

endmodule

// File: rtl/perm_round_ctrl.sv
// Iterative permutation controller: owns the state register and applies
// UNROLL rounds per cycle until the round index reaches ROUNDS_MAX.
module perm_round_ctrl
  import perm_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst,
  perm_round_ctrl_if.slave  bus,
  output ctrl_state_t       dbg_state
);

  ctrl_state_t        st_q, st_d;
  logic [3:0]         idx_q, idx_d;
  logic [STATE_W-1:0] state_q, state_d;

  logic [3:0]         n_clamp;
  logic [3:0]         remaining;
  logic [STATE_W-1:0] r0_out;
  logic [STATE_W-1:0] r1_out;

  assign n_clamp   = (bus.nrounds > ROUNDS_MAX_4) ? ROUNDS_MAX_4 : bus.nrounds;
  assign remaining = ROUNDS_MAX_4 - idx_q;

  perm_round u_round0 (
    .rnd_i (idx_q),
    .s_i   (state_q),
    .s_o   (r0_out)
  );

  generate
    if (UNROLL == 2) begin : g_unroll2
      perm_round u_round1 (
        .rnd_i (idx_q + 4'd1),
        .s_i   (r0_out),
        .s_o   (r1_out)
      );
    end else begin : g_unroll1
      assign r1_out = r0_out;
    end
  endgenerate

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    state_d = state_q;
    case (st_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = bus.state_in;
          if (n_clamp == 4'd0) begin
            st_d = ST_DONE;
          end else begin
            st_d  = ST_RUN;
            idx_d = ROUNDS_MAX_4 - n_clamp;
          end
        end
      end
      ST_RUN: begin
        // With one round left the second copy's output is bypassed.
        if ((UNROLL == 2) && (remaining >= 4'd2)) begin
          state_d = r1_out;
          idx_d   = idx_q + 4'd2;
        end else begin
          state_d = r0_out;
          idx_d   = idx_q + 4'd1;
        end
        if (idx_d == ROUNDS_MAX_4) begin
          st_d = ST_DONE;
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      idx_q   <= 4'd0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  assign bus.ready     = (st_q == ST_IDLE);
  assign bus.busy      = (st_q == ST_RUN);
  assign bus.done      = (st_q == ST_DONE);
  assign bus.state_out = state_q;
  assign dbg_state     = st_q;

endmodule

// File: tb/tb_perm_round_ctrl.sv
// Directed bench for perm_round_ctrl with UNROLL=1 and UNROLL=2 instances,
// checked against a table-driven software permutation model.
module tb_perm_round_ctrl;
  import perm_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  perm_round_ctrl_if if1 ();
  perm_round_ctrl_if if2 ();
  ctrl_state_t dbg1, dbg2;

  perm_round_ctrl #(.UNROLL(1)) u1 (.clk(clk), .rst(rst), .bus(if1), .dbg_state(dbg1));
  perm_round_ctrl #(.UNROLL(2)) u2 (.clk(clk), .rst(rst), .bus(if2), .dbg_state(dbg2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  // Reference permutation: column-wise S-box lookup, rounds first..11.
  function automatic logic [319:0] golden(input logic [319:0] s, input int first);
    logic [63:0] x [5];
    logic [4:0]  v;
    logic [4:0]  o;
    logic [7:0]  c;
    for (int k = 0; k < 5; k++) x[k] = s[319-64*k -: 64];
    for (int r = first; r < 12; r++) begin
      c = 8'(((15 - r) << 4) | r);
      x[2] = x[2] ^ {56'h0, c};
      for (int b = 0; b < 64; b++) begin
        v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = SBOX[v];
        x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
      end
      for (int k = 0; k < 5; k++)
        x[k] = x[k] ^ ((x[k] >> RA[k]) | (x[k] << (64 - RA[k])))
                    ^ ((x[k] >> RB[k]) | (x[k] << (64 - RB[k])));
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic drive(input int u, input logic st, input logic [3:0] n, input logic [319:0] s);
    if (u == 1) begin
      if1.start = st; if1.nrounds = n; if1.state_in = s;
    end else begin
      if2.start = st; if2.nrounds = n; if2.state_in = s;
    end
  endtask

  function automatic logic get_done(input int u);  return (u == 1) ? if1.done  : if2.done;  endfunction
  function automatic logic get_busy(input int u);  return (u == 1) ? if1.busy  : if2.busy;  endfunction
  function automatic logic get_ready(input int u); return (u == 1) ? if1.ready : if2.ready; endfunction
  function automatic logic [319:0] get_out(input int u);
    return (u == 1) ? if1.state_out : if2.state_out;
  endfunction

  // Call #1 after a posedge with ready=1. lat = edges until done is seen
  // (-1 on timeout); poke>0 re-pulses start with other data in that cycle.
  task automatic run_op(input int u, input logic [3:0] n, input logic [319:0] s,
                        input int poke, output int lat, output int busy_n,
                        output logic [319:0] res, output int done_cyc);
    bit seen;
    seen = 0; lat = 0; busy_n = 0; res = '0; done_cyc = -1;
    drive(u, 1'b1, n, s);
    while (!seen && lat < 40) begin
      @(posedge clk); lat++; #1;
      if (lat == poke) drive(u, 1'b1, 4'd3, ~s);
      else drive(u, 1'b0, n, s);
      @(negedge clk);
      if (get_busy(u)) busy_n++;
      if (get_done(u)) begin
        seen = 1; res = get_out(u); done_cyc = cyc;
      end
    end
    if (!seen) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1'b0, 4'd0, '0);
    drive(2, 1'b0, 4'd0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int u = 1; u <= 2; u++) begin
      checks += 4;
      if (get_ready(u) !== 1'b1) begin errors++; $display("FAIL reset_ready u%0d got=%b exp=1", u, get_ready(u)); end
      if (get_busy(u) !== 1'b0)  begin errors++; $display("FAIL reset_busy u%0d got=%b exp=0", u, get_busy(u)); end
      if (get_done(u) !== 1'b0)  begin errors++; $display("FAIL reset_done u%0d got=%b exp=0", u, get_done(u)); end
      if (get_out(u) !== 320'h0) begin errors++; $display("FAIL reset_state u%0d got=%h exp=0", u, get_out(u)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_round();
    int lat, bn, dc;
    logic [319:0] res, exp_v;
    exp_v = golden('0, 11);
    run_op(1, 4'd1, '0, 0, lat, bn, res, dc);
    checks += 3;
    if (lat !== 2) begin errors++; $display("FAIL p1_latency got=%0d exp=2", lat); end
    if (res[63:0] !== 64'h0) begin errors++; $display("FAIL p1_x4 got=%h exp=0", res[63:0]); end
    if (res !== exp_v) begin errors++; $display("FAIL p1_state got=%h exp=%h", res, exp_v); end
    @(posedge clk); #1;
  endtask

  task automatic test_p12();
    int lat, bn, dc;
    logic [319:0] res, exp_v;
    exp_v = golden('0, 0);
    for (int u = 1; u <= 2; u++) begin
      run_op(u, 4'd12, '0, 0, lat, bn, res, dc);
      checks += 3;
      if (lat !== ((u == 1) ? 13 : 7)) begin errors++; $display("FAIL p12_latency u%0d got=%0d exp=%0d", u, lat, (u == 1) ? 13 : 7); end
      if (bn !== ((u == 1) ? 12 : 6)) begin errors++; $display("FAIL p12_busy_cycles u%0d got=%0d exp=%0d", u, bn, (u == 1) ? 12 : 6); end
      if (res !== exp_v) begin errors++; $display("FAIL p12_state u%0d got=%h exp=%h", u, res, exp_v); end
      @(negedge clk);
      checks += 2;
      if (get_done(u) !== 1'b0) begin errors++; $display("FAIL p12_done_pulse u%0d got=%b exp=0", u, get_done(u)); end
      if (get_ready(u) !== 1'b1) begin errors++; $display("FAIL p12_ready_after u%0d got=%b exp=1", u, get_ready(u)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_and_clamp();
    int lat, bn, dc;
    logic [319:0] res, s, exp_v;
    for (int u = 1; u <= 2; u++) begin
      s = rand_state();
      run_op(u, 4'd0, s, 0, lat, bn, res, dc);
      checks += 2;
      if (lat !== 1) begin errors++; $display("FAIL p0_latency u%0d got=%0d exp=1", u, lat); end
      if (res !== s) begin errors++; $display("FAIL p0_passthru u%0d got=%h exp=%h", u, res, s); end
      @(posedge clk); #1;
    end
    s = rand_state();
    exp_v = golden(s, 0);
    run_op(1, 4'd15, s, 0, lat, bn, res, dc);
    checks += 2;
    if (lat !== 13) begin errors++; $display("FAIL p15_latency got=%0d exp=13", lat); end
    if (res !== exp_v) begin errors++; $display("FAIL p15_state got=%h exp=%h", res, exp_v); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start();
    int lat, bn, dc;
    logic [319:0] res, s, exp_v;
    s = rand_state();
    exp_v = golden(s, 5);
    run_op(2, 4'd7, s, 2, lat, bn, res, dc);
    checks += 2;
    if (lat !== 5) begin errors++; $display("FAIL u2p7_latency got=%0d exp=5", lat); end
    if (res !== exp_v) begin errors++; $display("FAIL u2p7_state got=%h exp=%h", res, exp_v); end
    repeat (3) @(negedge clk);
    checks++;
    if (if2.state_out !== exp_v) begin errors++; $display("FAIL u2p7_hold got=%h exp=%h", if2.state_out, exp_v); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int done_n, lat, bn, dc;
    logic [319:0] s, res, exp_v;
    s = rand_state();
    drive(1, 1'b1, 4'd12, s);
    @(posedge clk); #1 drive(1, 1'b0, 4'd12, s);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (if1.ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", if1.ready); end
    if (if1.busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got=%b exp=0", if1.busy); end
    if (if1.done !== 1'b0)  begin errors++; $display("FAIL abort_done got=%b exp=0", if1.done); end
    if (if1.state_out !== 320'h0) begin errors++; $display("FAIL abort_state got=%h exp=0", if1.state_out); end
    done_n = 0;
    repeat (15) begin
      @(negedge clk);
      if (if1.done) done_n++;
    end
    checks++;
    if (done_n !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_n); end
    @(posedge clk); #1;
    exp_v = golden(s, 6);
    run_op(1, 4'd6, s, 0, lat, bn, res, dc);
    checks++;
    if (res !== exp_v) begin errors++; $display("FAIL abort_recover got=%h exp=%h", res, exp_v); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, bn, dc1, dc2;
    logic [319:0] s1, s2, r1, r2, e1, e2;
    s1 = rand_state();
    s2 = rand_state();
    e1 = golden(s1, 0);
    e2 = golden(s2, 6);
    run_op(1, 4'd12, s1, 0, lat, bn, r1, dc1);
    @(posedge clk); #1;
    run_op(1, 4'd6, s2, 0, lat, bn, r2, dc2);
    checks += 3;
    if (r1 !== e1) begin errors++; $display("FAIL b2b_first got=%h exp=%h", r1, e1); end
    if (r2 !== e2) begin errors++; $display("FAIL b2b_second got=%h exp=%h", r2, e2); end
    if (dc2 - dc1 !== 8) begin errors++; $display("FAIL b2b_gap got=%0d exp=8", dc2 - dc1); end
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_round();
    test_p12();
    test_zero_and_clamp();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
